histogram_accumulator: RTL and testbench

//  Parametrised histogram counting stage, first step of the equalizer. Reads NUM_WORDS packed

---
 rtl/histogram_accumulator_if.sv | 33 +++
 rtl/histogram_accumulator.sv | 205 ++++++++++++++++++++
 tb/tb_histogram_accumulator.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/histogram_accumulator_if.sv
// Memory-side bundle of the histogram stage: input-image read port and scratchpad read/write ports.
// Latency: none (wires only); both memories return read data one clock after the address.
// Backpressure: none; the stage owns both memories for the duration of a run.
//
// Ports (master = histogram stage, slave = memories):
//   in_raddr  m->s  input word index          in_rdata  s->m  packed pixel word
//   sp_raddr  m->s  {bank,bin} read address   sp_rdata  s->m  bin count
//   sp_waddr  m->s  {bank,bin} write address  sp_wdata  m->s  bin count
//   sp_we     m->s  scratchpad write enable
interface histogram_accumulator_if #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 16,
  parameter int COUNT_W      = 16,
  parameter int ADDR_W       = 16
);
  logic [ADDR_W-1:0]             in_raddr;
  logic [PIX_W*PIX_PER_WORD-1:0] in_rdata;
  logic [PIX_W:0]                sp_raddr;
  logic [COUNT_W-1:0]            sp_rdata;
  logic [PIX_W:0]                sp_waddr;
  logic [COUNT_W-1:0]            sp_wdata;
  logic                          sp_we;

  modport master (
    output in_raddr, sp_raddr, sp_waddr, sp_wdata, sp_we,
    input  in_rdata, sp_rdata
  );

  modport slave (
    input  in_raddr, sp_raddr, sp_waddr, sp_wdata, sp_we,
    output in_rdata, sp_rdata
  );
endinterface

// File: rtl/histogram_accumulator.sv
// Histogram stage: optionally clears a scratchpad bank, then counts NUM_WORDS*PIX_PER_WORD pixels into it.
// Latency: done rises CLR+N+4 clocks after start is sampled (CLR = 2**PIX_W when clearing, else 0).
// Backpressure: none; one bin per clock while clearing, one pixel per clock while counting.
//
// Ports:
//   clock, rst_n          clock and asynchronous active-low reset
//   start                 level request; sampled in IDLE together with clear_en and bank_sel
//   clear_en, bank_sel    zero the bank before counting / scratchpad bank (address MSB)
//   busy, done, overflow  run in progress / run complete (held until start low) / sticky saturation
//   mem                   master side of histogram_accumulator_if (input memory + scratchpad)
module histogram_accumulator #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 16,
  parameter int NUM_WORDS    = 4,
  parameter int COUNT_W      = 16,
  parameter int ADDR_W       = 16
) (
  input  logic clock,
  input  logic rst_n,
  input  logic start,
  input  logic clear_en,
  input  logic bank_sel,
  output logic busy,
  output logic done,
  output logic overflow,
  histogram_accumulator_if.master mem
);

  localparam int NPIX   = NUM_WORDS * PIX_PER_WORD;
  localparam int CNT_W  = $clog2(NPIX + 2);
  localparam int LANE_W = $clog2(PIX_PER_WORD);

  // COUNT cycle 0 is the prefetch, cycles 1..N extract pixels, cycle N+1 has the last pixel in stage A.
  localparam logic [CNT_W-1:0]   CNT_N       = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(NPIX + 1);
  localparam logic [LANE_W-1:0]  LANE_LAST   = LANE_W'(PIX_PER_WORD - 1);
  localparam logic [LANE_W-1:0]  LANE_PRE    = LANE_W'(PIX_PER_WORD - 2);
  localparam logic [ADDR_W-1:0]  RADDR_LAST  = ADDR_W'(NUM_WORDS - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX   = {COUNT_W{1'b1}};
  localparam logic [PIX_W-1:0]   BIN_LAST    = {PIX_W{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COUNT, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic              bank_q,  bank_d;
  logic [PIX_W-1:0]  clr_q,   clr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [LANE_W-1:0] lane_q,  lane_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              drain_q, drain_d;
  logic              ovf_q,   ovf_d;

  // Pixel pipeline: X (extract, registered into A), A (scratchpad read), B (increment), C (write),
  // W (write committed last cycle, kept for forwarding).
  logic [PIX_W-1:0]   pa_q, pb_q, pc_q, pw_q;
  logic               pa_vld_q, pb_vld_q, pc_vld_q, pw_vld_q;
  logic [COUNT_W-1:0] pc_cnt_q, pw_cnt_q;

  logic               start_acc;
  logic               ext_vld;
  logic [PIX_W-1:0]   pix_ext;
  logic [COUNT_W-1:0] fwd_cnt;
  logic               sat;
  logic [COUNT_W-1:0] inc_cnt;

  assign start_acc = (state_q == S_IDLE) && start;
  assign ext_vld   = (state_q == S_COUNT) && (cnt_q != '0) && (cnt_q <= CNT_N);
  assign pix_ext   = mem.in_rdata[int'(lane_q) * PIX_W +: PIX_W];

  // Scratchpad reads return pre-write data, so the two most recent writes may be newer than sp_rdata.
  always_comb begin : forward
    fwd_cnt = mem.sp_rdata;
    if (pc_vld_q && (pc_q == pb_q)) begin
      fwd_cnt = pc_cnt_q;
    end else if (pw_vld_q && (pw_q == pb_q)) begin
      fwd_cnt = pw_cnt_q;
    end
    sat     = (fwd_cnt == COUNT_MAX);
    inc_cnt = sat ? fwd_cnt : fwd_cnt + COUNT_W'(1);
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = clear_en ? S_CLEAR : S_COUNT;
      S_CLEAR: if (clr_q == BIN_LAST) state_d = S_COUNT;
      S_COUNT: if (cnt_q == CNT_LAST) state_d = S_DRAIN;
      S_DRAIN: if (drain_q) state_d = S_DONE;
      S_DONE:  if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin : outputs
    busy         = 1'b0;
    done         = 1'b0;
    mem.sp_we    = pc_vld_q;
    mem.sp_waddr = {bank_q, pc_q};
    mem.sp_wdata = pc_cnt_q;
    case (state_q)
      S_CLEAR: begin
        busy         = 1'b1;
        mem.sp_we    = 1'b1;
        mem.sp_waddr = {bank_q, clr_q};
        mem.sp_wdata = '0;
      end
      S_COUNT, S_DRAIN: busy = 1'b1;
      S_DONE:           done = 1'b1;
      default: ;
    endcase
  end

  assign mem.in_raddr = raddr_q;
  assign mem.sp_raddr = {bank_q, pa_q};
  assign overflow     = ovf_q;

  // ---------------- control counters ----------------
  always_comb begin : ctrl_next
    bank_d  = bank_q;
    clr_d   = clr_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    raddr_d = raddr_q;
    drain_d = drain_q;
    ovf_d   = ovf_q | (pb_vld_q & sat);
    if (start_acc) begin
      bank_d  = bank_sel;
      clr_d   = '0;
      cnt_d   = '0;
      lane_d  = '0;
      raddr_d = '0;
      drain_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (state_q == S_CLEAR) clr_d = clr_q + 1'b1;
      if (state_q == S_COUNT) cnt_d = cnt_q + 1'b1;
      if (ext_vld) begin
        lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + 1'b1;
        // Fetch the next word one clock before its first lane is needed, so words abut with no bubble.
        if ((lane_q == LANE_PRE) && (raddr_q != RADDR_LAST)) raddr_d = raddr_q + 1'b1;
      end
      if (state_q == S_DRAIN) drain_d = ~drain_q;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bank_q  <= 1'b0;
      clr_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= '0;
      raddr_q <= '0;
      drain_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      bank_q  <= bank_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      raddr_q <= raddr_d;
      drain_q <= drain_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------- pixel pipeline ----------------
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pa_q     <= '0;
      pb_q     <= '0;
      pc_q     <= '0;
      pw_q     <= '0;
      pa_vld_q <= 1'b0;
      pb_vld_q <= 1'b0;
      pc_vld_q <= 1'b0;
      pw_vld_q <= 1'b0;
      pc_cnt_q <= '0;
      pw_cnt_q <= '0;
    end else begin
      if (ext_vld) pa_q <= pix_ext;
      pa_vld_q <= ext_vld;
      pb_q     <= pa_q;
      pb_vld_q <= pa_vld_q;
      pc_q     <= pb_q;
      pc_cnt_q <= inc_cnt;
      pc_vld_q <= pb_vld_q;
      pw_q     <= pc_q;
      pw_cnt_q <= pc_cnt_q;
      pw_vld_q <= pc_vld_q;
    end
  end

endmodule

// File: tb/tb_histogram_accumulator.sv
module tb_histogram_accumulator;

  localparam int PW  = 8;
  localparam int PPW = 16;
  localparam int NW  = 4;
  localparam int AW  = 16;

  logic clock = 1'b0;
  logic rst_n;
  logic start0, start1, clear_en, bank_sel;
  logic busy0, done0, ovf0;
  logic busy1, done1, ovf1;
  logic mem_init;

  histogram_accumulator_if #(.PIX_W(PW), .PIX_PER_WORD(PPW), .COUNT_W(16), .ADDR_W(AW)) m0 ();
  histogram_accumulator_if #(.PIX_W(PW), .PIX_PER_WORD(PPW), .COUNT_W(4),  .ADDR_W(AW)) m1 ();

  histogram_accumulator #(.PIX_W(PW), .PIX_PER_WORD(PPW), .NUM_WORDS(NW), .COUNT_W(16), .ADDR_W(AW)) dut0 (
    .clock(clock), .rst_n(rst_n), .start(start0), .clear_en(clear_en), .bank_sel(bank_sel),
    .busy(busy0), .done(done0), .overflow(ovf0), .mem(m0)
  );

  histogram_accumulator #(.PIX_W(PW), .PIX_PER_WORD(PPW), .NUM_WORDS(NW), .COUNT_W(4), .ADDR_W(AW)) dut1 (
    .clock(clock), .rst_n(rst_n), .start(start1), .clear_en(clear_en), .bank_sel(bank_sel),
    .busy(busy1), .done(done1), .overflow(ovf1), .mem(m1)
  );

  always #5 clock = ~clock;

  logic [PW*PPW-1:0] in_mem [NW];
  logic [15:0]       sp_mem0 [512];
  logic [3:0]        sp_mem1 [512];
  int                model0 [512];
  int                model1 [512];
  logic [7:0]        img [64];
  logic [24:0]       sb_q [$];
  int                checks = 0;
  int                errors = 0;

  // Memories: registered reads (read-old on a same-address write), no reset of contents.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) begin
        sp_mem0[i] <= (i < 256) ? 16'(32'hA500 ^ i) : 16'h0000;
        sp_mem1[i] <= 4'(i * 7 + 3);
      end
    end else begin
      if (m0.sp_we) sp_mem0[m0.sp_waddr] <= m0.sp_wdata;
      if (m1.sp_we) sp_mem1[m1.sp_waddr] <= m1.sp_wdata;
    end
    m0.in_rdata <= in_mem[m0.in_raddr[1:0]];
    m1.in_rdata <= in_mem[m1.in_raddr[1:0]];
    m0.sp_rdata <= sp_mem0[m0.sp_raddr];
    m1.sp_rdata <= sp_mem1[m1.sp_raddr];
  end

  task automatic load_img;
    for (int k = 0; k < 64; k++) in_mem[k / 16][(k % 16) * 8 +: 8] = img[k];
  endtask

  // Pushes the expected write stream from the bench model, starts one DUT and scores every write
  // until done. Returns clocks from the start-sampling edge to the first cycle done is seen.
  task automatic run(input int dut, input bit clr, input bit bank, output int cycles, output bit ovf);
    int          v;
    int          vmax;
    logic [8:0]  a;
    logic        we, dn, bz, ov, stop;
    logic [8:0]  wa;
    logic [15:0] wd;
    logic [24:0] exp_e;
    vmax = (dut == 0) ? 65535 : 15;
    if (clr) begin
      for (int b = 0; b < 256; b++) begin
        a = {bank, 8'(b)};
        if (dut == 0) model0[a] = 0; else model1[a] = 0;
        sb_q.push_back({a, 16'h0000});
      end
    end
    for (int k = 0; k < 64; k++) begin
      a = {bank, img[k]};
      v = (dut == 0) ? model0[a] : model1[a];
      if (v < vmax) v++;
      if (dut == 0) model0[a] = v; else model1[a] = v;
      sb_q.push_back({a, 16'(v)});
    end
    clear_en = clr;
    bank_sel = bank;
    if (dut == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clock);
    cycles = 0;
    stop   = 1'b0;
    while (!stop) begin
      #1;
      if (dut == 0) begin
        we = m0.sp_we; wa = m0.sp_waddr; wd = m0.sp_wdata; dn = done0; bz = busy0; ov = ovf0;
      end else begin
        we = m1.sp_we; wa = m1.sp_waddr; wd = 16'(m1.sp_wdata); dn = done1; bz = busy1; ov = ovf1;
      end
      if (cycles == 0) begin
        checks++;
        if (bz !== 1'b1 || ov !== 1'b0) begin
          errors++;
          $display("FAIL start_accept dut%0d: busy=%b overflow=%b, want busy=1 overflow=0", dut, bz, ov);
        end
      end
      if (we !== 1'b0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected dut%0d cycle %0d: write addr=%h data=%h, none expected", dut, cycles, wa, wd);
        end else begin
          exp_e = sb_q.pop_front();
          if (we !== 1'b1 || {wa, wd} !== exp_e) begin
            errors++;
            $display("FAIL sb_write dut%0d cycle %0d: we=%b addr=%h data=%h, want addr=%h data=%h",
                     dut, cycles, we, wa, wd, exp_e[24:16], exp_e[15:0]);
          end
        end
      end
      if (dn === 1'b1) begin
        stop = 1'b1;
      end else if (cycles >= 2000) begin
        checks++;
        errors++;
        $display("FAIL done_timeout dut%0d: no done after %0d clocks, want done", dut, cycles);
        stop = 1'b1;
      end else begin
        @(posedge clock);
        cycles++;
      end
    end
    ovf = ov;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover dut%0d: %0d expected writes missing, want 0", dut, sb_q.size());
    end
    sb_q.delete();
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    dn = (dut == 0) ? done0 : done1;
    bz = (dut == 0) ? busy0 : busy1;
    checks++;
    if (dn !== 1'b1 || bz !== 1'b0) begin
      errors++;
      $display("FAIL done_hold dut%0d: done=%b busy=%b with start high, want done=1 busy=0", dut, dn, bz);
    end
    if (dut == 0) start0 = 1'b0; else start1 = 1'b0;
    @(posedge clock);
    #1;
    dn = (dut == 0) ? done0 : done1;
    checks++;
    if (dn !== 1'b0) begin
      errors++;
      $display("FAIL done_release dut%0d: done=%b after start low, want 0", dut, dn);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy0, done0, ovf0, m0.sp_we} !== 4'b0000 || m0.in_raddr !== 16'h0 || m0.sp_raddr !== 9'h0) begin
      errors++;
      $display("FAIL reset_dut0: busy/done/ovf/we=%b in_raddr=%h sp_raddr=%h, want all 0",
               {busy0, done0, ovf0, m0.sp_we}, m0.in_raddr, m0.sp_raddr);
    end
    checks++;
    if ({busy1, done1, ovf1, m1.sp_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_dut1: busy/done/ovf/we=%b, want 0000", {busy1, done1, ovf1, m1.sp_we});
    end
    mem_init = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy0, done0, m0.sp_we} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: busy/done/we=%b, want 000", {busy0, done0, m0.sp_we});
    end
  endtask

  task automatic test_clear_count;
    int cyc; bit ov; int bad;
    for (int k = 0; k < 64; k++) img[k] = 8'h05;
    load_img();
    run(0, 1'b1, 1'b0, cyc, ov);
    checks++;
    if (cyc != 256 + 64 + 4) begin
      errors++;
      $display("FAIL t1_done_cycles: got %0d, want %0d", cyc, 256 + 64 + 4);
    end
    checks++;
    if (sp_mem0[5] !== 16'd64) begin
      errors++;
      $display("FAIL t1_bin5: got %0d, want 64", sp_mem0[5]);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (i != 5 && sp_mem0[i] !== 16'h0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL t1_other_bins: %0d nonzero bins, want 0", bad);
    end
    checks++;
    if (ov !== 1'b0 || m0.in_raddr !== 16'd3) begin
      errors++;
      $display("FAIL t1_ovf_raddr: overflow=%b in_raddr=%0d, want 0 and 3", ov, m0.in_raddr);
    end
  endtask

  task automatic test_accumulate;
    int cyc; bit ov;
    run(0, 1'b0, 1'b0, cyc, ov);
    checks++;
    if (cyc != 64 + 4) begin
      errors++;
      $display("FAIL t4_done_cycles: got %0d, want %0d", cyc, 64 + 4);
    end
    checks++;
    if (sp_mem0[5] !== 16'd128 || ov !== 1'b0) begin
      errors++;
      $display("FAIL t4_bin5: got %0d overflow=%b, want 128 overflow=0", sp_mem0[5], ov);
    end
  endtask

  task automatic test_hazard;
    int cyc; bit ov;
    for (int k = 0; k < 64; k++) img[k] = (k % 2 == 0) ? 8'h11 : 8'h22;
    load_img();
    run(0, 1'b1, 1'b0, cyc, ov);
    checks++;
    if (sp_mem0[8'h11] !== 16'd32 || sp_mem0[8'h22] !== 16'd32 || sp_mem0[5] !== 16'd0) begin
      errors++;
      $display("FAIL t2_bins: 0x11=%0d 0x22=%0d 0x05=%0d, want 32 32 0",
               sp_mem0[8'h11], sp_mem0[8'h22], sp_mem0[5]);
    end
  endtask

  task automatic test_bank_sel;
    int cyc; bit ov; int bad0; int bad1;
    logic [15:0] snap [256];
    for (int i = 0; i < 256; i++) snap[i] = sp_mem0[i];
    for (int k = 0; k < 64; k++) img[k] = 8'(k);
    load_img();
    run(0, 1'b0, 1'b1, cyc, ov);
    checks++;
    if (cyc != 64 + 4) begin
      errors++;
      $display("FAIL t3_done_cycles: got %0d, want %0d", cyc, 64 + 4);
    end
    bad1 = 0;
    for (int i = 0; i < 256; i++) if (sp_mem0[256 + i] !== ((i < 64) ? 16'd1 : 16'd0)) bad1++;
    bad0 = 0;
    for (int i = 0; i < 256; i++) if (sp_mem0[i] !== snap[i]) bad0++;
    checks++;
    if (bad1 != 0 || bad0 != 0) begin
      errors++;
      $display("FAIL t3_banks: %0d wrong bank1 bins, %0d changed bank0 bins, want 0 and 0", bad1, bad0);
    end
  endtask

  task automatic test_saturate;
    int cyc; bit ov;
    for (int k = 0; k < 64; k++) img[k] = 8'hFF;
    load_img();
    run(1, 1'b1, 1'b0, cyc, ov);
    checks++;
    if (sp_mem1[255] !== 4'd15 || ov !== 1'b1) begin
      errors++;
      $display("FAIL t5_saturate: bin 0xFF=%0d overflow=%b, want 15 and 1", sp_mem1[255], ov);
    end
    checks++;
    if (cyc != 256 + 64 + 4) begin
      errors++;
      $display("FAIL t5_done_cycles: got %0d, want %0d", cyc, 256 + 64 + 4);
    end
    for (int k = 0; k < 64; k++) img[k] = 8'(k);
    load_img();
    run(1, 1'b0, 1'b0, cyc, ov);
    checks++;
    if (ov !== 1'b0 || sp_mem1[10] !== 4'd1 || sp_mem1[255] !== 4'd15) begin
      errors++;
      $display("FAIL t5_rerun: overflow=%b bin10=%0d bin255=%0d, want 0 1 15", ov, sp_mem1[10], sp_mem1[255]);
    end
  endtask

  task automatic test_reset_abort;
    int cyc; bit ov; int bad;
    for (int k = 0; k < 64; k++) img[k] = 8'h05;
    load_img();
    clear_en = 1'b0;
    bank_sel = 1'b0;
    start0   = 1'b1;
    @(posedge clock);
    repeat (30) @(posedge clock);
    #1;
    checks++;
    if (m0.sp_we !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL t6_mid_count: sp_we=%b busy=%b, want 1 1", m0.sp_we, busy0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m0.sp_we, busy0, done0} !== 3'b000) begin
      errors++;
      $display("FAIL t6_abort: sp_we/busy/done=%b within reset cycle, want 000", {m0.sp_we, busy0, done0});
    end
    clear_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b1;
    run(0, 1'b1, 1'b0, cyc, ov);
    bad = 0;
    for (int i = 0; i < 256; i++) if (sp_mem0[i] !== ((i == 5) ? 16'd64 : 16'd0)) bad++;
    checks++;
    if (cyc != 256 + 64 + 4 || bad != 0) begin
      errors++;
      $display("FAIL t6_rerun: done at %0d with %0d wrong bins, want %0d and 0", cyc, bad, 256 + 64 + 4);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_init = 1'b1;
    start0   = 1'b0;
    start1   = 1'b0;
    clear_en = 1'b0;
    bank_sel = 1'b0;
    for (int i = 0; i < 512; i++) begin
      model0[i] = (i < 256) ? ((32'hA500 ^ i) & 32'hFFFF) : 0;
      model1[i] = (i * 7 + 3) & 15;
    end
    test_reset();
    test_clear_count();
    test_accumulate();
    test_hazard();
    test_bank_sel();
    test_saturate();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
